// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: turns byte/half/word requests into word-addressed
// RAM accesses, splitting boundary-straddling accesses in two and merging load data.
module mem_lsu #(
    parameter int MEM_WORDS = 8192,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    input  logic              i_write,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rdata,
    output logic              o_err,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] w0_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              write_q;
    logic              split_q;
    logic [31:0]       lo_q;

    // Request decode, evaluated on the incoming request before acceptance
    logic [2:0]  req_nbytes;
    logic        req_split;
    logic [31:0] req_w0;
    logic [31:0] req_w1;
    logic        req_err;

    always_comb begin
        case (i_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
        req_split = ({1'b0, i_addr[1:0]} + req_nbytes) > 3'd4;
        req_w0    = {2'b00, i_addr[31:2]};
        req_w1    = req_w0 + 32'd1;
        // Range is checked on the full index so out-of-range never aliases to low words
        req_err   = (i_size == 2'b11) || (req_w0 >= MEM_WORDS_W) ||
                    (req_split && (req_w1 >= MEM_WORDS_W));
    end

    // Lane placement of the latched request
    logic [3:0]  mask;
    logic [7:0]  be64;
    logic [31:0] wd_clean;
    logic [63:0] wd64;

    always_comb begin
        case (size_q)
            2'b00: begin
                mask     = 4'b0001;
                wd_clean = {24'h0, wdata_q[7:0]};
            end
            2'b01: begin
                mask     = 4'b0011;
                wd_clean = {16'h0, wdata_q[15:0]};
            end
            default: begin
                mask     = 4'b1111;
                wd_clean = wdata_q;
            end
        endcase
        be64 = {4'b0000, mask} << off_q;
        wd64 = {32'h0, wd_clean} << {off_q, 3'b000};
    end

    // Load merge: lo word is held from SECOND, hi (or only) word comes straight from RAM
    logic [63:0] merged;
    logic [31:0] ld_d;
    logic [31:0] ld_result;

    always_comb begin
        merged = split_q ? {i_mem_rdata, lo_q} : {32'h0, i_mem_rdata};
        ld_d   = merged[{off_q, 3'b000} +: 32];
        case (size_q)
            2'b00:   ld_result = sign_q ? {24'h0, ld_d[7:0]}
                                        : {{24{ld_d[7]}}, ld_d[7:0]};
            2'b01:   ld_result = sign_q ? {16'h0, ld_d[15:0]}
                                        : {{16{ld_d[15]}}, ld_d[15:0]};
            default: ld_result = ld_d;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            w0_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            split_q <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && i_req_valid) begin
                w0_q    <= i_addr[ADDR_W+1:2];
                off_q   <= i_addr[1:0];
                wdata_q <= i_wdata;
                size_q  <= i_size;
                sign_q  <= i_sign;
                write_q <= i_write;
                split_q <= req_split;
            end
            if (state_q == S_SECOND) begin
                lo_q <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rdata     = '0;
        o_err       = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    state_d = req_err ? S_ERR : S_FIRST;
                end
            end
            S_FIRST: begin
                o_mem_en   = 1'b1;
                o_mem_we   = write_q;
                o_mem_addr = w0_q;
                if (write_q) begin
                    o_mem_be    = be64[3:0];
                    o_mem_wdata = wd64[31:0];
                end
                state_d = split_q ? S_SECOND : S_DONE;
            end
            S_SECOND: begin
                o_mem_en   = 1'b1;
                o_mem_we   = write_q;
                o_mem_addr = w0_q + ADDR_W'(1);
                if (write_q) begin
                    o_mem_be    = be64[7:4];
                    o_mem_wdata = wd64[63:32];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                o_rsp_valid = 1'b1;
                o_rdata     = write_q ? 32'h0 : ld_result;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                o_rsp_valid = 1'b1;
                o_err       = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: expected RAM accesses and responses are queued at issue
// time and checked by a negedge monitor against a behavioural 1-cycle-latency RAM.
module tb_mem_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [1:0]  i_size = '0;
    logic        i_sign = 1'b0;
    logic        i_write = 1'b0;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [12:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;

    mem_lsu #(.MEM_WORDS(8192)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_size      (i_size),
        .i_sign      (i_sign),
        .i_write     (i_write),
        .o_rsp_valid (o_rsp_valid),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] ram [0:8191];
    logic [31:0] ram_q = '0;
    assign i_mem_rdata = ram_q;

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (o_mem_be[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            end else begin
                ram_q <= ram[o_mem_addr];
            end
        end
    end

    typedef struct {
        logic [12:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
    } mem_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    mem_t memq[$];
    rsp_t rspq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (i_req_valid && o_req_ready) acc_cyc = cyc + 1;
            if (o_mem_en) begin
                if (memq.size() == 0) begin
                    chk("mem_unexpected", 32'(o_mem_en), 32'd0);
                end else begin
                    mem_t e;
                    e = memq.pop_front();
                    chk("mem_addr", 32'(o_mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(o_mem_we), 32'(e.we));
                    chk("mem_be", 32'(o_mem_be), 32'(e.be));
                    chk("mem_wdata", o_mem_wdata, e.wd);
                end
            end
            if (o_rsp_valid) begin
                if (rspq.size() == 0) begin
                    chk("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
                end else begin
                    rsp_t r;
                    r = rspq.pop_front();
                    chk("rsp_rdata", o_rdata, r.rdata);
                    chk("rsp_err", 32'(o_err), 32'(r.err));
                    chk("rsp_latency", 32'(cyc - acc_cyc + 1), 32'(r.lat));
                end
            end else begin
                chk("idle_rdata", o_rdata, 32'h0);
                chk("idle_err", 32'(o_err), 32'd0);
            end
        end
    end

    task automatic exp_mem(input logic [12:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
        mem_t e;
        e.addr = a; e.we = we; e.be = be; e.wd = wd;
        memq.push_back(e);
    endtask

    task automatic exp_rsp(input logic [31:0] rd, input logic err, input int lat);
        rsp_t r;
        r.rdata = rd; r.err = err; r.lat = lat;
        rspq.push_back(r);
    endtask

    // Called at posedge+1; accepted on the next edge
    task automatic send(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                        input logic sg, input logic wr);
        chk("ready_before_req", 32'(o_req_ready), 32'd1);
        i_addr = a; i_wdata = wd; i_size = sz; i_sign = sg; i_write = wr;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(rspq.size() == 0 && memq.size() == 0 && o_req_ready) && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("drain_timeout", 32'(n < 20), 32'd1);
        chk("drain_rsp_left", 32'(rspq.size()), 32'd0);
        chk("drain_mem_left", 32'(memq.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
        ram[4]    = 32'hDEADBEEF;
        ram[1]    = 32'hAB000000;
        ram[2]    = 32'h000000CD;
        ram[8191] = 32'hCAFEF00D;

        #22;
        chk("rst_ready", 32'(o_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_mem_en", 32'(o_mem_en), 32'd0);
        chk("rst_mem_we", 32'(o_mem_we), 32'd0);
        chk("rst_mem_be", 32'(o_mem_be), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Aligned word load
        exp_mem(13'd4, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'hDEADBEEF, 1'b0, 2);
        send(32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();

        // Byte loads at offset 3, signed then unsigned
        ram[4] = 32'h80123456;
        exp_mem(13'd4, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'hFFFFFF80, 1'b0, 2);
        send(32'h13, 32'h0, 2'b00, 1'b0, 1'b0);
        drain();
        exp_mem(13'd4, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'h00000080, 1'b0, 2);
        send(32'h13, 32'h0, 2'b00, 1'b1, 1'b0);
        drain();

        // Split word store across words 3/4
        exp_mem(13'd3, 1'b1, 4'b1100, 32'h33440000);
        exp_mem(13'd4, 1'b1, 4'b0011, 32'h00001122);
        exp_rsp(32'h0, 1'b0, 3);
        send(32'h0E, 32'h11223344, 2'b10, 1'b0, 1'b1);
        drain();
        chk("ram3_after_sw", ram[3], 32'h33440000);
        chk("ram4_after_sw", ram[4], 32'h80121122);
        exp_mem(13'd4, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'h80121122, 1'b0, 2);
        send(32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();

        // Split half loads across words 1/2
        exp_mem(13'd1, 1'b0, 4'b0000, 32'h0);
        exp_mem(13'd2, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'hFFFFCDAB, 1'b0, 3);
        send(32'h07, 32'h0, 2'b01, 1'b0, 1'b0);
        drain();
        exp_mem(13'd1, 1'b0, 4'b0000, 32'h0);
        exp_mem(13'd2, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'h0000CDAB, 1'b0, 3);
        send(32'h07, 32'h0, 2'b01, 1'b1, 1'b0);
        drain();

        // Byte store with junk in upper wdata bits, then half load over it
        exp_mem(13'd8, 1'b1, 4'b0010, 32'h0000A500);
        exp_rsp(32'h0, 1'b0, 2);
        send(32'h21, 32'hFFFFFFA5, 2'b00, 1'b0, 1'b1);
        drain();
        exp_mem(13'd8, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'hFFFFA500, 1'b0, 2);
        send(32'h20, 32'h0, 2'b01, 1'b0, 1'b0);
        drain();

        // Errors: illegal size, split past the end, fully out of range
        exp_rsp(32'h0, 1'b1, 1);
        send(32'h0, 32'h0, 2'b11, 1'b0, 1'b0);
        drain();
        exp_rsp(32'h0, 1'b1, 1);
        send(32'h7FFE, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();
        exp_rsp(32'h0, 1'b1, 1);
        send(32'h8000, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();

        // Last word is in range
        exp_mem(13'd8191, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'hCAFEF00D, 1'b0, 2);
        send(32'h7FFC, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();

        // Reset during SECOND of a split store
        ram[3] = 32'h0;
        ram[4] = 32'h55555555;
        exp_mem(13'd3, 1'b1, 4'b1100, 32'h33440000);
        send(32'h0E, 32'h11223344, 2'b10, 1'b0, 1'b1);
        @(posedge i_clk); #1;
        chk("second_mem_en", 32'(o_mem_en), 32'd1);
        i_reset_n = 1'b0;
        #1;
        chk("async_mem_en", 32'(o_mem_en), 32'd0);
        chk("async_ready", 32'(o_req_ready), 32'd1);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_mid_memq", 32'(memq.size()), 32'd0);
        chk("ram3_first_half", ram[3], 32'h33440000);
        chk("ram4_untouched", ram[4], 32'h55555555);
        exp_mem(13'd4, 1'b0, 4'b0000, 32'h0);
        exp_rsp(32'h55555555, 1'b0, 2);
        send(32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        drain();

        repeat (2) @(posedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
